// File: rtl/seg_scan_rx.sv
// seg_scan_rx: receive side of a 6-digit multiplexed 7-segment scan bus.
// Waits for each digit to settle, decodes it to BCD and rebuilds HH:MM:SS frames.
module seg_scan_rx #(
  parameter int SETTLE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i_seg,
  input  logic       i_seg_dp,
  input  logic [5:0] i_seg_enb,
  output logic [5:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [5:0] o_dp,
  output logic       o_frame_vld,
  output logic       o_bad_frame,
  output logic       o_seq_err,
  output logic       o_locked
);

  localparam int            CW        = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SETTLE_CYC);
  localparam logic [CW-1:0] CNT_CAP   = CW'(SETTLE_CYC - 1);
  localparam logic [5:0]    ENB_BLANK = 6'h3F;

  logic [5:0]    enb_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [CW-1:0] settle_cnt;
  logic [2:0]    exp_idx;
  logic [3:0]    slot_digit [6];
  logic [5:0]    slot_ok;
  logic [5:0]    slot_dp;
  logic          frame_pend;

  logic          changed;
  logic          capture;
  logic          one_cold;
  logic [2:0]    dig_idx;
  logic [4:0]    dec;
  logic          frame_good;

  // Returns {valid, bcd}; unknown patterns give an invalid 4'hF.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h7E:   return 5'h10;
      7'h30:   return 5'h11;
      7'h6D:   return 5'h12;
      7'h79:   return 5'h13;
      7'h33:   return 5'h14;
      7'h5B:   return 5'h15;
      7'h5F:   return 5'h16;
      7'h70:   return 5'h17;
      7'h7F:   return 5'h18;
      7'h73:   return 5'h19;
      default: return 5'h0F;
    endcase
  endfunction

  function automatic logic [5:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
    return {2'b00, tens} * 6'd10 + {2'b00, ones};
  endfunction

  // NOTE: every signal gets a value before any condition, so no latch is inferred.
  always_comb begin
    changed  = {i_seg_enb, i_seg, i_seg_dp} != {enb_q, seg_q, dp_q};
    capture  = !changed && (settle_cnt == CNT_CAP);
    one_cold = $onehot(~enb_q);
    dig_idx  = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (!enb_q[i]) dig_idx = 3'(i);
    end
    dec = decode(seg_q);
    // Hour is range-checked on the BCD digits so an invalid tens digit cannot wrap.
    frame_good = (&slot_ok) && (slot_digit[1] <= 4'd5) && (slot_digit[3] <= 4'd5) &&
                 ((slot_digit[5] < 4'd2) ||
                  ((slot_digit[5] == 4'd2) && (slot_digit[4] <= 4'd3)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enb_q       <= ENB_BLANK;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      settle_cnt  <= '0;
      exp_idx     <= '0;
      frame_pend  <= 1'b0;
      // NOTE: the slots are plain flops, so they are reset to keep stale digits out of a new frame.
      for (int i = 0; i < 6; i++) slot_digit[i] <= 4'h0;
      slot_ok     <= '0;
      slot_dp     <= '0;
      o_hour      <= '0;
      o_min       <= '0;
      o_sec       <= '0;
      o_dp        <= '0;
      o_frame_vld <= 1'b0;
      o_bad_frame <= 1'b0;
      o_seq_err   <= 1'b0;
      o_locked    <= 1'b0;
    end else begin
      enb_q <= i_seg_enb;
      seg_q <= i_seg;
      dp_q  <= i_seg_dp;

      if (changed) settle_cnt <= '0;
      else if (settle_cnt != CNT_MAX) settle_cnt <= settle_cnt + CW'(1);

      o_frame_vld <= 1'b0;
      o_bad_frame <= 1'b0;
      o_seq_err   <= 1'b0;
      frame_pend  <= 1'b0;

      // Frame judged one edge after digit 5 is stored.
      if (frame_pend) begin
        if (frame_good) begin
          o_hour      <= bcd2bin(slot_digit[5], slot_digit[4]);
          o_min       <= bcd2bin(slot_digit[3], slot_digit[2]);
          o_sec       <= bcd2bin(slot_digit[1], slot_digit[0]);
          o_dp        <= slot_dp;
          o_frame_vld <= 1'b1;
          o_locked    <= 1'b1;
        end else begin
          o_bad_frame <= 1'b1;
          o_locked    <= 1'b0;
        end
      end

      if (capture && (enb_q != ENB_BLANK)) begin
        if (!one_cold) begin
          o_seq_err <= 1'b1;
          o_locked  <= 1'b0;
          slot_ok   <= '0;
          exp_idx   <= '0;
        end else if (dig_idx == exp_idx) begin
          slot_digit[dig_idx] <= dec[3:0];
          slot_ok[dig_idx]    <= dec[4];
          slot_dp[dig_idx]    <= dp_q;
          if (dig_idx == 3'd5) begin
            frame_pend <= 1'b1;
            exp_idx    <= '0;
          end else begin
            exp_idx <= dig_idx + 3'd1;
          end
        end else begin
          o_seq_err <= 1'b1;
          o_locked  <= 1'b0;
          if (dig_idx == 3'd0) begin
            slot_digit[0] <= dec[3:0];
            slot_ok       <= {5'b00000, dec[4]};
            slot_dp[0]    <= dp_q;
            exp_idx       <= 3'd1;
          end else begin
            slot_ok <= '0;
            exp_idx <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_rx.sv
// Self-checking bench for seg_scan_rx: directed scenarios plus randomized frames
// checked against a digit-level model of the scan protocol.
module tb_seg_scan_rx;

  localparam int         S     = 4;
  localparam logic [5:0] BLANK = 6'h3F;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] i_seg;
  logic       i_seg_dp;
  logic [5:0] i_seg_enb;
  logic [5:0] o_hour, o_min, o_sec, o_dp;
  logic       o_frame_vld, o_bad_frame, o_seq_err, o_locked;

  seg_scan_rx #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .i_seg(i_seg), .i_seg_dp(i_seg_dp), .i_seg_enb(i_seg_enb),
    .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec), .o_dp(o_dp),
    .o_frame_vld(o_frame_vld), .o_bad_frame(o_bad_frame), .o_seq_err(o_seq_err),
    .o_locked(o_locked)
  );

  always #10 clk = ~clk;

  int    tests_run    = 0;
  int    tests_failed = 0;
  int    cyc          = 0;
  int    overlap      = 0;
  string obs_s        = "";
  string exp_s        = "";

  logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};

  always @(posedge clk) cyc <= cyc + 1;

  // Pulses are logged with the index of the edge that launched them.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (o_frame_vld === 1'b1)
        obs_s = {obs_s, $sformatf("V@%0d:%0d/%0d/%0d/%02h ", cyc, o_hour, o_min, o_sec, o_dp)};
      if (o_bad_frame === 1'b1) obs_s = {obs_s, $sformatf("B@%0d ", cyc)};
      if (o_seq_err === 1'b1)   obs_s = {obs_s, $sformatf("S@%0d ", cyc)};
      if (int'(o_frame_vld) + int'(o_bad_frame) + int'(o_seq_err) > 1) overlap++;
    end
  end

  // ---------------- reference model (digit/frame level) ----------------
  int          m_exp;
  int          m_d [6];
  bit          m_v [6];
  bit   [5:0]  m_dp;
  int          m_hour, m_min, m_sec;
  bit   [5:0]  m_odp;
  bit          m_locked;
  bit          cur_valid;
  logic [13:0] cur_val;
  int          cur_load, cur_len;

  function automatic int decode_model(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (seg_tab[d] == s) return d;
    return -1;
  endfunction

  task automatic model_reset();
    m_exp = 0; m_dp = '0; m_hour = 0; m_min = 0; m_sec = 0; m_odp = '0; m_locked = 0;
    for (int i = 0; i < 6; i++) begin m_d[i] = 0; m_v[i] = 0; end
    cur_valid = 0;
  endtask

  task automatic model_store(input int k, input int d, input logic dp);
    m_v[k]  = (d >= 0);
    m_d[k]  = (d >= 0) ? d : 15;
    m_dp[k] = dp;
  endtask

  task automatic model_capture(input logic [13:0] v, input int t);
    logic [5:0] enb;
    int zeros, k, d, hour;
    bit good;
    enb = v[13:8];
    if (enb == BLANK) return;
    zeros = 0; k = 0;
    for (int i = 0; i < 6; i++) if (!enb[i]) begin zeros++; k = i; end
    if (zeros > 1) begin
      exp_s = {exp_s, $sformatf("S@%0d ", t)}; m_locked = 0; m_exp = 0;
      return;
    end
    d = decode_model(v[7:1]);
    if (k == m_exp) begin
      model_store(k, d, v[0]);
      if (k == 5) begin
        hour = 10 * m_d[5] + m_d[4];
        good = m_v[0] && m_v[1] && m_v[2] && m_v[3] && m_v[4] && m_v[5] &&
               m_d[1] <= 5 && m_d[3] <= 5 && hour <= 23;
        if (good) begin
          m_hour = hour; m_min = 10 * m_d[3] + m_d[2]; m_sec = 10 * m_d[1] + m_d[0];
          m_odp = m_dp; m_locked = 1;
          exp_s = {exp_s, $sformatf("V@%0d:%0d/%0d/%0d/%02h ", t + 1, m_hour, m_min, m_sec, m_odp)};
        end else begin
          m_locked = 0;
          exp_s = {exp_s, $sformatf("B@%0d ", t + 1)};
        end
        m_exp = 0;
      end else begin
        m_exp = k + 1;
      end
    end else begin
      exp_s = {exp_s, $sformatf("S@%0d ", t)}; m_locked = 0;
      if (k == 0) begin model_store(0, d, v[0]); m_exp = 1; end
      else m_exp = 0;
    end
  endtask

  // A value stable for more than S edges is captured S edges after it loads.
  task automatic model_hold(input logic [13:0] v, input int load, input int n);
    if (cur_valid && v == cur_val && load == cur_load + cur_len) begin
      cur_len += n;
    end else begin
      if (cur_valid && cur_len >= S + 1) model_capture(cur_val, cur_load + S);
      cur_valid = 1; cur_val = v; cur_load = load; cur_len = n;
    end
  endtask

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic hold(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int n);
    i_seg_enb = enb; i_seg = seg; i_seg_dp = dp;
    model_hold({enb, seg, dp}, cyc + 1, n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [5:0] enb_of(input int k);
    return 6'(~(6'b000001 << k));
  endfunction

  task automatic send_frame(input int h, input int m, input int s, input bit [5:0] dp, input int n);
    int d [6];
    d = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
    for (int k = 0; k < 6; k++) hold(enb_of(k), seg_tab[d[k]], dp[k], n);
    hold(BLANK, 7'h00, 1'b0, 8);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; i_seg_enb = BLANK; i_seg = '0; i_seg_dp = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({o_hour, o_min, o_sec, o_dp} !== 24'h0) begin
      tests_failed++; $display("FAIL reset_data: got %h expected 0", {o_hour, o_min, o_sec, o_dp});
    end
    tests_run++;
    if ({o_frame_vld, o_bad_frame, o_seq_err, o_locked} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {o_frame_vld, o_bad_frame, o_seq_err, o_locked});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_good_frame();
    send_frame(12, 34, 56, 6'b010100, 10);
    tests_run++;
    if (obs_s != exp_s) begin tests_failed++; $display("FAIL good_events: got '%s' expected '%s'", obs_s, exp_s); end
    tests_run++;
    if ({o_hour, o_min, o_sec} !== {6'd12, 6'd34, 6'd56}) begin
      tests_failed++; $display("FAIL good_time: got %0d:%0d:%0d expected 12:34:56", o_hour, o_min, o_sec);
    end
    tests_run++;
    if (o_dp !== 6'b010100 || o_locked !== 1'b1) begin
      tests_failed++; $display("FAIL good_dp_lock: got dp=%b lock=%b expected dp=010100 lock=1", o_dp, o_locked);
    end
    obs_s = ""; exp_s = "";
  endtask

  task automatic test_glitch_seq();
    int d [6];
    d = '{6, 5, 4, 3, 2, 1};
    for (int k = 0; k < 6; k++) hold(enb_of(k), seg_tab[d[k]], 1'b0, (k == 3) ? 3 : 10);
    hold(BLANK, 7'h00, 1'b0, 8);
    tests_run++;
    if (obs_s != exp_s) begin tests_failed++; $display("FAIL glitch_events: got '%s' expected '%s'", obs_s, exp_s); end
    tests_run++;
    if (o_locked !== 1'b0 || {o_hour, o_min, o_sec} !== {6'd12, 6'd34, 6'd56}) begin
      tests_failed++;
      $display("FAIL glitch_hold: got lock=%b %0d:%0d:%0d expected lock=0 12:34:56", o_locked, o_hour, o_min, o_sec);
    end
    obs_s = ""; exp_s = "";
  endtask

  task automatic test_bad_hour();
    send_frame(12, 34, 56, 6'b000000, 10);
    send_frame(25, 0, 0, 6'b111111, 10);
    tests_run++;
    if (obs_s != exp_s) begin tests_failed++; $display("FAIL bad_hour_events: got '%s' expected '%s'", obs_s, exp_s); end
    tests_run++;
    if (o_locked !== 1'b0 || {o_hour, o_min, o_sec, o_dp} !== {6'd12, 6'd34, 6'd56, 6'd0}) begin
      tests_failed++;
      $display("FAIL bad_hour_hold: got lock=%b %0d:%0d:%0d dp=%b expected lock=0 12:34:56 dp=000000",
               o_locked, o_hour, o_min, o_sec, o_dp);
    end
    obs_s = ""; exp_s = "";
  endtask

  task automatic test_blank_seg();
    for (int k = 0; k < 6; k++) hold(enb_of(k), (k == 1) ? 7'h00 : seg_tab[1], 1'b0, 10);
    hold(BLANK, 7'h00, 1'b0, 8);
    tests_run++;
    if (obs_s != exp_s) begin tests_failed++; $display("FAIL blank_seg_events: got '%s' expected '%s'", obs_s, exp_s); end
    tests_run++;
    if (o_hour !== 6'd12) begin tests_failed++; $display("FAIL blank_seg_hold: got %0d expected 12", o_hour); end
    obs_s = ""; exp_s = "";
  endtask

  task automatic test_restart();
    for (int k = 0; k < 3; k++) hold(enb_of(k), seg_tab[k + 4], 1'b0, 10);
    send_frame(1, 2, 3, 6'b100001, 10);
    tests_run++;
    if (obs_s != exp_s) begin tests_failed++; $display("FAIL restart_events: got '%s' expected '%s'", obs_s, exp_s); end
    tests_run++;
    if ({o_hour, o_min, o_sec} !== {6'd1, 6'd2, 6'd3} || o_locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_time: got %0d:%0d:%0d lock=%b expected 1:2:3 lock=1", o_hour, o_min, o_sec, o_locked);
    end
    obs_s = ""; exp_s = "";
  endtask

  task automatic test_settle_boundary();
    send_frame(9, 8, 7, 6'b000000, S + 1);
    for (int k = 0; k < 6; k++) hold(enb_of(k), seg_tab[k], 1'b0, (k == 2) ? S : S + 1);
    hold(BLANK, 7'h00, 1'b0, 8);
    tests_run++;
    if (obs_s != exp_s) begin tests_failed++; $display("FAIL boundary_events: got '%s' expected '%s'", obs_s, exp_s); end
    tests_run++;
    if ({o_hour, o_min, o_sec} !== {6'd9, 6'd8, 6'd7}) begin
      tests_failed++; $display("FAIL boundary_time: got %0d:%0d:%0d expected 9:8:7", o_hour, o_min, o_sec);
    end
    obs_s = ""; exp_s = "";
  endtask

  task automatic test_multi_zero();
    send_frame(4, 5, 6, 6'b000000, 10);
    hold(enb_of(0), seg_tab[2], 1'b0, 10);
    hold(enb_of(1), seg_tab[2], 1'b0, 10);
    hold(6'b110011, seg_tab[2], 1'b0, 10);
    hold(BLANK, 7'h00, 1'b0, 8);
    tests_run++;
    if (obs_s != exp_s) begin tests_failed++; $display("FAIL multi_zero_events: got '%s' expected '%s'", obs_s, exp_s); end
    tests_run++;
    if (o_locked !== 1'b0) begin tests_failed++; $display("FAIL multi_zero_lock: got %b expected 0", o_locked); end
    obs_s = ""; exp_s = "";
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int h = $urandom_range(0, 23);
      int m = $urandom_range(0, 59);
      int s = $urandom_range(0, 59);
      int mode = $urandom_range(0, 7);
      int bad_k = $urandom_range(0, 5);
      bit [5:0] dp = 6'($urandom);
      int d [6];
      d = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
      if (mode == 1) begin d[5] = 2; d[4] = $urandom_range(4, 9); end
      for (int k = 0; k < 6; k++) begin
        logic [5:0] enb = enb_of(k);
        logic [6:0] sg = seg_tab[d[k]];
        int n = $urandom_range(S + 1, S + 8);
        if (mode == 2 && k == bad_k) sg = 7'($urandom);
        if (mode == 3 && k == bad_k) n = $urandom_range(1, S);
        if (mode == 4 && k == bad_k) enb = enb_of((bad_k + 2) % 6);
        if (mode == 5 && k == bad_k) enb = enb_of(k) & enb_of((k + 3) % 6);
        if ($urandom_range(0, 3) == 0) hold(BLANK, 7'h00, 1'b0, $urandom_range(1, 6));
        hold(enb, sg, dp[k], n);
      end
      hold(BLANK, 7'h00, 1'b0, 8);
      tests_run++;
      if (obs_s != exp_s) begin
        tests_failed++; $display("FAIL rand_events[%0d]: got '%s' expected '%s'", it, obs_s, exp_s);
      end
      tests_run++;
      if (o_hour !== 6'(m_hour) || o_min !== 6'(m_min) || o_sec !== 6'(m_sec) ||
          o_dp !== m_odp || o_locked !== m_locked) begin
        tests_failed++;
        $display("FAIL rand_state[%0d]: got %0d:%0d:%0d dp=%b lock=%b expected %0d:%0d:%0d dp=%b lock=%b",
                 it, o_hour, o_min, o_sec, o_dp, o_locked, m_hour, m_min, m_sec, m_odp, m_locked);
      end
      obs_s = ""; exp_s = "";
    end
  endtask

  task automatic test_reset_mid();
    send_frame(10, 20, 30, 6'b001000, 10);
    for (int k = 0; k < 4; k++) hold(enb_of(k), seg_tab[7 - k], 1'b0, 10);
    hold(enb_of(4), seg_tab[1], 1'b0, 2);
    tests_run++;
    if (obs_s != exp_s || o_locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset: got '%s' lock=%b expected '%s' lock=1", obs_s, o_locked, exp_s);
    end
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if ({o_hour, o_min, o_sec, o_dp, o_frame_vld, o_bad_frame, o_seq_err, o_locked} !== 28'h0) begin
      tests_failed++;
      $display("FAIL mid_reset: got %0d:%0d:%0d dp=%b flags=%b expected all 0", o_hour, o_min, o_sec, o_dp,
               {o_frame_vld, o_bad_frame, o_seq_err, o_locked});
    end
    i_seg_enb = BLANK; i_seg = '0; i_seg_dp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    obs_s = ""; exp_s = "";
    send_frame(23, 59, 59, 6'b000000, 10);
    tests_run++;
    if (obs_s != exp_s) begin tests_failed++; $display("FAIL post_reset_events: got '%s' expected '%s'", obs_s, exp_s); end
    tests_run++;
    if ({o_hour, o_min, o_sec} !== {6'd23, 6'd59, 6'd59} || o_locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_time: got %0d:%0d:%0d lock=%b expected 23:59:59 lock=1", o_hour, o_min, o_sec, o_locked);
    end
    obs_s = ""; exp_s = "";
  endtask

  task automatic test_exclusive();
    tests_run++;
    if (overlap !== 0) begin tests_failed++; $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch_seq();
    test_bad_hour();
    test_blank_seg();
    test_restart();
    test_settle_boundary();
    test_multi_zero();
    test_random();
    test_reset_mid();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg_scan_rx.md
Name: seg_scan_rx

Overview:
- Receive side of the multiplexed 6-digit 7-segment scan bus driven by the display driver.
- Watches the seg, dp and one-cold digit-enable lines and waits for each digit to settle.
- Decodes each settled segment pattern back to BCD and reassembles complete HH:MM:SS frames as binary hour/min/sec.
- Used as an on-chip display checker and as a bench-side monitor; same clock domain as the driver.

Parameters:
- SETTLE_CYC, 16: consecutive clk edges the inputs must stay unchanged before a digit is captured (range 2..255).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, asynchronous, active-high.
- i_seg  in  7  segments {a..g}, active-high, a = bit 6.
- i_seg_dp  in  1  decimal point of the active digit.
- i_seg_enb  in  6  digit enables, active-low one-cold; bit k low selects digit k (0 = sec ones … 5 = hour tens).
- o_hour  out  6  last good frame, hours 0..23.
- o_min  out  6  last good frame, minutes 0..59.
- o_sec  out  6  last good frame, seconds 0..59.
- o_dp  out  6  dp bits of the last good frame, bit k = digit k.
- o_frame_vld  out  1  1-cycle pulse when the outputs above are updated.
- o_bad_frame  out  1  1-cycle pulse: a complete frame was rejected.
- o_seq_err  out  1  1-cycle pulse: scan order violated.
- o_locked  out  1  high after a good frame; low after any bad frame or seq error.

Behaviour:
- Reset (async, rst=1): input register loads enb=6'h3F, seg=0, dp=0; settle counter=0; expected index=0; slots cleared; all outputs 0.
- Input register samples {i_seg_enb, i_seg, i_seg_dp} every edge.
- Settle counter:
  - Cleared to 0 on any edge where the new sample differs from the registered value.
  - Otherwise increments, saturating at SETTLE_CYC.
- Capture event: the edge where the counter goes SETTLE_CYC-1 -> SETTLE_CYC. If the input is loaded at edge n and held, capture is at edge n+SETTLE_CYC. Inputs held fewer cycles are ignored as glitches. There is exactly one capture per stable window.
- Enable classification at capture:
  - enb = 6'h3F (blank): no action.
  - Exactly one zero at bit k: digit capture k.
  - More than one zero: o_seq_err pulse, partial frame discarded, expected index = 0.
- Decode table: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=73. Any other pattern stores 4'hF and marks the slot invalid.
- Ordering on a digit capture k:
  - k == expected: store digit and dp; expected = k+1.
  - k != expected and k == 0: o_seq_err pulse; discard partial frame; store digit 0; expected = 1.
  - k != expected and k != 0: o_seq_err pulse; discard partial frame; expected = 0.
- Frame completion happens on a store to slot 5.
  - Checks: every slot decodes validly; sec tens ≤ 5; min tens ≤ 5; hour ≤ 23.
  - Pass: at the next edge, update o_hour = 10·d5+d4, o_min = 10·d3+d2, o_sec = 10·d1+d0 and o_dp; pulse o_frame_vld; set o_locked.
  - Fail: pulse o_bad_frame at that same next edge; leave outputs unchanged; clear o_locked.
  - In both cases expected = 0.
- o_seq_err clears o_locked in the same cycle it pulses.
- Only one pulse output can be high in any cycle.
- The data outputs hold their values between good frames.
- Reset asserted mid-frame returns everything to the reset state immediately; no pulse is produced.

Test Plan:
- SETTLE_CYC=4; scan 12:34:56 in order 0..5, each digit held 10 cycles -> o_frame_vld one cycle, 5 edges after digit 5 loads; o_hour=12, o_min=34, o_sec=56; o_locked=1.
- Digit 3 held only 3 cycles between digits 2 and 4 -> no capture; digit 4 arrives with expected=3 -> o_seq_err pulse, o_locked=0, outputs unchanged.
- Full frame with hour digits 2,5 (25) -> o_bad_frame pulse, no o_frame_vld, outputs keep 12:34:56.
- Seg pattern 7'h00 on digit 1 within a full frame -> o_bad_frame pulse.
- Scan restarts at digit 0 after digit 2 -> o_seq_err; the following complete 0..5 frame gives o_frame_vld with new values.
- Assert rst while digit 4 is settling -> all outputs 0 at once; a subsequent clean frame of 23:59:59 -> o_frame_vld, o_hour=23, o_min=59, o_sec=59.
